pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the program counter register for the single-issue RISC-V core and produces every next-PC decision. It chooses between sequential PC+4, a branch/jump target and a trap vector. It also drives the pipeline flush and fetch-valid signals. It sits in front of instruction fetch and consumes the OR'd branch/jump decision from the execute stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 1, bubble cycles inserted after any redirect (legal range 1..7)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold PC (hazard / memory wait)
br_taken  in  1  branch taken or jump, from branch OR logic
br_target  in  32  PC+Imm or JALR target
trap_req  in  1  exception/interrupt redirect request
trap_vec  in  32  trap handler address
pc  out  32  current fetch address, registered
pc_plus4  out  32  pc + 4, combinational, wraps modulo 2^32
fetch_valid  out  1  fetch at pc is architecturally valid
flush  out  1  squash younger in-flight instructions, 1-cycle pulse
misalign_err  out  1  taken branch target had br_target[1:0] != 0, 1-cycle pulse

Behaviour:
- States: BOOT, RUN, FLUSH. 3-bit bubble counter cnt.
- Reset (rst=1 at a clock edge), from any state including mid-FLUSH:
  - state <= BOOT, pc <= RESET_PC, cnt <= 0.
  - fetch_valid, flush and misalign_err are 0 while rst is high and in BOOT.
- BOOT: all inputs ignored; next cycle goes to RUN with pc unchanged. The first valid fetch is at RESET_PC, one cycle after rst deasserts.
- fetch_valid = (state == RUN). flush and misalign_err are combinational and asserted only in the cycle a redirect is accepted.
- RUN priority, highest first:
  1. trap_req: pc <= {trap_vec[31:2], 2'b00}; flush=1; cnt <= FLUSH_CYCLES; go to FLUSH.
  2. br_taken with br_target[1:0] == 0: pc <= br_target; flush=1; cnt <= FLUSH_CYCLES; go to FLUSH.
  3. br_taken with br_target[1:0] != 0: pc <= {trap_vec[31:2], 2'b00}; flush=1; misalign_err=1; cnt <= FLUSH_CYCLES; go to FLUSH.
  4. stall: pc holds; stay in RUN.
  5. Otherwise: pc <= pc_plus4.
- A redirect overrides stall when both are asserted in the same cycle.
- FLUSH:
  - fetch_valid=0; pc holds; cnt decrements each cycle; go to RUN when cnt reaches 1 at the edge. This gives exactly FLUSH_CYCLES invalid cycles after the redirect cycle.
  - br_taken and stall are ignored.
  - trap_req in FLUSH: pc <= aligned trap_vec, flush=1, cnt reloads to FLUSH_CYCLES, stay in FLUSH.
- Wrap-around: pc = 32'hFFFF_FFFC with no redirect gives pc_plus4 = 0, and next pc = 0. No error is raised.
- trap_vec[1:0] is always forced to 0. A misaligned trap_vec never raises misalign_err.
- No latches; every output is defined in every state.

Test Plan:
- Reset/boot: RESET_PC=32'h100; hold rst 3 cycles, then release → pc=0x100 with fetch_valid=0 for 1 cycle, then fetch_valid=1, then pc=0x104, 0x108 on consecutive cycles.
- Taken branch: at pc=0x108 assert br_taken with br_target=0x200 → flush=1 that cycle; next cycle pc=0x200 with fetch_valid=0 for FLUSH_CYCLES=1 cycle; then pc=0x200 with fetch_valid=1, then 0x204.
- Stall vs redirect: stall=1 for 3 cycles at pc=0x40 → pc stays 0x40 with fetch_valid=1. Then assert stall=1 and br_taken=1 (target 0x80) together → pc=0x80 and flush=1; the branch wins.
- Trap priority and misalignment: br_taken with br_target=0x81 and trap_vec=0x1000 → misalign_err=1, flush=1, pc=0x1000. Separately, trap_req together with br_taken (target 0x300) → pc=trap_vec and misalign_err=0.
- FLUSH_CYCLES=3: redirect to 0x500 → exactly 3 cycles of fetch_valid=0. Assert trap_req (trap_vec=0x2002) in the 2nd bubble → pc=0x2000 and 3 new bubble cycles.
- Wrap and mid-op reset: pc=0xFFFF_FFFC → next pc=0x0. Assert rst during FLUSH → BOOT, pc=RESET_PC, no flush pulse.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter register and next-PC selection (sequential, branch, trap)
// with fetch-valid, flush pulse and bubble insertion after every redirect.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misalign_err
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
    localparam logic [2:0] FC = 3'(FLUSH_CYCLES);
    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] trap_pc;
    logic        misalign;
    logic        run;
    assign trap_pc      = {trap_vec[31:2], 2'b00};
    assign misalign     = br_taken && br_target[1:0] != 2'b00;
    assign run          = state == RUN && !rst;
    assign pc_plus4     = pc + 32'd4;
    assign fetch_valid  = run;
    assign misalign_err = run && !trap_req && misalign;
    assign flush        = (run && (trap_req || br_taken)) || (!rst && state == FLUSH && trap_req);
    // A misaligned branch target is redirected to the trap vector like a trap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
            cnt   <= 3'd0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (trap_req || misalign) begin
                        pc    <= trap_pc;
                        cnt   <= FC;
                        state <= FLUSH;
                    end else if (br_taken) begin
                        pc    <= br_target;
                        cnt   <= FC;
                        state <= FLUSH;
                    end else if (!stall) begin
                        pc <= pc_plus4;
                    end
                end
                FLUSH: begin
                    if (trap_req) begin
                        pc  <= trap_pc;
                        cnt <= FC;
                    end else begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1) state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench driving two sequencers (1 and 3 bubble cycles)
// with shared stimulus and comparing against a cycle model.
module tb_pc_sequencer;
    logic        clk = 0;
    logic        rst, stall, br_taken, trap_req;
    logic [31:0] br_target, trap_vec;
    logic [31:0] pc [2];
    logic [31:0] pc_plus4 [2];
    logic        fetch_valid [2];
    logic        flush [2];
    logic        misalign_err [2];
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int          k;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        mis;
    } exp_t;
    exp_t q[$];

    int          m_st [2];
    logic [31:0] m_pc [2];
    int          m_left [2];
    int          fcs [2] = '{1, 3};

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h100), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .trap_req(trap_req), .trap_vec(trap_vec), .pc(pc[0]), .pc_plus4(pc_plus4[0]),
        .fetch_valid(fetch_valid[0]), .flush(flush[0]), .misalign_err(misalign_err[0])
    );
    pc_sequencer #(.RESET_PC(32'h100), .FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .trap_req(trap_req), .trap_vec(trap_vec), .pc(pc[1]), .pc_plus4(pc_plus4[1]),
        .fetch_valid(fetch_valid[1]), .flush(flush[1]), .misalign_err(misalign_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // model states: 0 boot, 1 run, 2 bubbles pending
    task automatic model_expect(input int k);
        exp_t e;
        logic run;
        run = !rst && m_st[k] == 1;
        e.k   = k;
        e.pc  = m_pc[k];
        e.fv  = run;
        e.fl  = (run && (trap_req || br_taken)) || (!rst && m_st[k] == 2 && trap_req);
        e.mis = run && !trap_req && br_taken && (br_target[1:0] != 2'b00);
        q.push_back(e);
    endtask

    task automatic model_step(input int k);
        logic [31:0] tv;
        tv = trap_vec & 32'hFFFF_FFFC;
        if (rst) begin
            m_st[k] = 0; m_pc[k] = 32'h100; m_left[k] = 0;
        end else if (m_st[k] == 0) begin
            m_st[k] = 1;
        end else if (m_st[k] == 1) begin
            if (trap_req || (br_taken && br_target[1:0] != 2'b00)) begin
                m_pc[k] = tv; m_st[k] = 2; m_left[k] = fcs[k];
            end else if (br_taken) begin
                m_pc[k] = br_target; m_st[k] = 2; m_left[k] = fcs[k];
            end else if (!stall) begin
                m_pc[k] = m_pc[k] + 32'd4;
            end
        end else begin
            if (trap_req) begin
                m_pc[k] = tv; m_left[k] = fcs[k];
            end else begin
                m_left[k]--;
                if (m_left[k] == 0) m_st[k] = 1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic bt, input logic [31:0] tgt,
                       input logic tr, input logic [31:0] tv);
        exp_t e;
        rst = r; stall = s; br_taken = bt; br_target = tgt; trap_req = tr; trap_vec = tv;
        #1;
        for (int k = 0; k < 2; k++) model_expect(k);
        while (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("pc%0d", e.k), pc[e.k], e.pc);
            check($sformatf("plus4_%0d", e.k), pc_plus4[e.k], e.pc + 32'd4);
            check($sformatf("fv%0d", e.k), 32'(fetch_valid[e.k]), 32'(e.fv));
            check($sformatf("flush%0d", e.k), 32'(flush[e.k]), 32'(e.fl));
            check($sformatf("mis%0d", e.k), 32'(misalign_err[e.k]), 32'(e.mis));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; stall = 0; br_taken = 0; br_target = 0; trap_req = 0; trap_vec = 0;
        for (int k = 0; k < 2; k++) begin m_st[k] = 0; m_pc[k] = 32'h100; m_left[k] = 0; end
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 32'h44, 1, 32'h8);
        cyc(0, 1, 1, 32'h44, 1, 32'h8);
        idle(2);
        check("boot_pc", pc[0], 32'h108);
        cyc(0, 0, 1, 32'h200, 0, 0);
        idle(5);
        cyc(0, 0, 1, 32'h40, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
        check("stall_pc", pc[0], 32'h40);
        cyc(0, 1, 1, 32'h80, 0, 0);
        check("stall_br_pc", pc[0], 32'h80);
        idle(4);
        cyc(0, 0, 1, 32'h81, 0, 32'h1000);
        check("mis_pc", pc[0], 32'h1000);
        idle(4);
        cyc(0, 0, 1, 32'h300, 1, 32'h1000);
        idle(4);
        cyc(0, 0, 0, 0, 1, 32'h1003);
        idle(4);
        cyc(0, 0, 1, 32'h500, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 1, 32'h2002);
        check("bubble_trap_pc", pc[1], 32'h2000);
        idle(5);
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        idle(1);
        check("wrap_plus4", pc_plus4[0], 32'h0);
        idle(4);
        cyc(0, 0, 1, 32'h600, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'h700);
        check("midflush_rst_pc", pc[1], 32'h100);
        idle(3);
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                $urandom, $urandom_range(0, 9) == 0, $urandom);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
